// File: rtl/fp_issue_queue_pkg.sv
// Shared encodings for the FP issue queue: float_alu op codes, flag bit
// positions and the sequencer state type.
package fp_issue_queue_pkg;

    // Op-code encoding understood by float_alu
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_BUSY  = 2'd3
    } iq_state_e;

    // True for op codes that float_alu actually implements
    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request FIFO: synchronous-reset circular buffer with occupancy count.
// No bypass: a pushed entry becomes visible on the following cycle.
module fp_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [AW:0]                 count_q;
    logic                        do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fp_issue_queue.sv
// FP issue queue: buffers requests, issues them one at a time to float_alu
// with operands held steady for the whole op, returns tagged results through
// a registered slot and accumulates sticky IEEE flags.
module fp_issue_queue
    import fp_issue_queue_pkg::*;
#(
    parameter int P     = 23,
    parameter int E     = 8,
    parameter int N     = P + E + 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic [2:0]       req_op,
    input  logic             req_mode_fp,
    input  logic             req_round,
    input  logic [TAG_W-1:0] req_tag,
    output logic [N-1:0]     alu_op_a,
    output logic [N-1:0]     alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_mode_fp,
    output logic             alu_round_mode,
    output logic             alu_start,
    output logic             alu_ready_in,
    input  logic             alu_valid_out,
    input  logic             alu_ready_out,
    input  logic [N-1:0]     alu_result,
    input  logic [4:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic [4:0]       res_flags,
    output logic [TAG_W-1:0] res_tag,
    output logic [4:0]       flags_sticky,
    input  logic             flags_clr,
    output logic             busy
);
    localparam int FW = TAG_W + 2 + 3 + 2*N;
    localparam logic [4:0] NV_ONLY = 5'(1) << FLAG_NV;

    // FIFO interface
    logic [FW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [N-1:0]     h_a, h_b;
    logic [2:0]       h_op;
    logic             h_mode, h_round;
    logic [TAG_W-1:0] h_tag;

    // Sequencer state and held operands
    iq_state_e        state_q;
    logic [N-1:0]     op_a_q, op_b_q;
    logic [2:0]       op_code_q;
    logic             mode_q, round_q;
    logic [TAG_W-1:0] tag_q;

    // Output slot and sticky flags
    logic             res_valid_q;
    logic [N-1:0]     res_data_q;
    logic [4:0]       res_flags_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [4:0]       sticky_q;

    logic             slot_free, legal, cap_alu, cap_ill, capture;
    logic [N-1:0]     cap_data;
    logic [4:0]       cap_flags;

    assign fifo_wdata = {req_tag, req_round, req_mode_fp, req_op, req_b, req_a};
    assign {h_tag, h_round, h_mode, h_op, h_b, h_a} = fifo_rdata;
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    fp_req_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid && req_ready),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Held during reset so nothing is accepted that the reset would discard
    assign req_ready = rst_n && !fifo_full;

    assign slot_free    = !res_valid_q || res_ready;
    assign legal        = op_legal(op_code_q);
    // start tracks ALU readiness directly so it is a one-cycle pulse
    assign alu_start    = (state_q == ST_START) && legal && alu_ready_out;
    assign alu_ready_in = (state_q == ST_BUSY) && slot_free;
    assign cap_alu      = (state_q == ST_BUSY) && alu_valid_out && alu_ready_in;
    // Illegal ops never reach the ALU; they retire with an NV-only result
    assign cap_ill      = (state_q == ST_START) && !legal && slot_free;
    assign capture      = cap_alu || cap_ill;
    assign cap_data     = cap_alu ? alu_result : '0;
    assign cap_flags    = cap_alu ? alu_flags : NV_ONLY;

    assign alu_op_a       = op_a_q;
    assign alu_op_b       = op_b_q;
    assign alu_op_code    = op_code_q;
    assign alu_mode_fp    = mode_q;
    assign alu_round_mode = round_q;

    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign res_tag      = res_tag_q;
    assign flags_sticky = sticky_q;
    assign busy         = !fifo_empty || (state_q != ST_IDLE) || res_valid_q;

    // Issue sequencer; held registers only change on a pop in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            mode_q    <= 1'b0;
            round_q   <= 1'b0;
            tag_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_a_q    <= h_a;
                        op_b_q    <= h_b;
                        op_code_q <= h_op;
                        mode_q    <= h_mode;
                        round_q   <= h_round;
                        tag_q     <= h_tag;
                        state_q   <= ST_LOAD;
                    end
                end
                // Gives float_alu a cycle to remux ready_out for the new op
                ST_LOAD:  state_q <= ST_START;
                ST_START: begin
                    if (alu_start)    state_q <= ST_BUSY;
                    else if (cap_ill) state_q <= ST_IDLE;
                end
                ST_BUSY: begin
                    if (cap_alu) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Result slot; a capture wins over a same-cycle drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_tag_q   <= '0;
        end else if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= cap_data;
            res_flags_q <= cap_flags;
            res_tag_q   <= tag_q;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    // Sticky flags; clear with capture keeps only the new flags
    always_ff @(posedge clk) begin
        if (!rst_n)         sticky_q <= '0;
        else if (capture)   sticky_q <= (flags_clr ? 5'b0 : sticky_q) | cap_flags;
        else if (flags_clr) sticky_q <= '0;
    end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Bench for fp_issue_queue: behavioural float_alu model, scoreboard of
// expected tagged results, directed scenarios.
module tb_fp_issue_queue;
    import fp_issue_queue_pkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_mode_fp, req_round;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_op;
    logic [3:0]  req_tag;
    logic [31:0] alu_op_a, alu_op_b, alu_result;
    logic [2:0]  alu_op_code;
    logic        alu_mode_fp, alu_round_mode, alu_start, alu_ready_in;
    logic        alu_valid_out, alu_ready_out;
    logic [4:0]  alu_flags;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_flags, flags_sticky;
    logic [3:0]  res_tag;
    logic        flags_clr, busy;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_err = 0;
    int n_start = 0, n_rx = 0;
    int alu_lat_fixed = 0;

    fp_issue_queue dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_mode_fp(req_mode_fp), .req_round(req_round), .req_tag(req_tag),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
        .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_start(alu_start), .alu_ready_in(alu_ready_in),
        .alu_valid_out(alu_valid_out), .alu_ready_out(alu_ready_out),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_tag(res_tag),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference float_alu behaviour for the vectors used here: {flags, result}
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h33800000) return {5'b00001, 32'h3F800000};
        if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return {5'b00000, 32'h40C00000};
        if (op == OP_DIV && a == 32'h40C00000 && b == 32'h40000000) return {5'b00000, 32'h40400000};
        if (op == OP_DIV && b[30:0] == 31'd0) return {5'b01000, a[31] ^ b[31], 31'h7F800000};
        return {5'b00000, a ^ {b[15:0], b[31:16]} ^ {29'd0, op}};
    endfunction

    // float_alu model: accepts start when ready, random latency, holds result until taken
    logic       m_busy = 1'b0;
    int         m_lat = 0;
    logic [2:0] m_op = '0;
    always @(posedge clk) begin
        logic [36:0] r;
        if (!rst_n) begin
            m_busy        <= 1'b0;
            alu_valid_out <= 1'b0;
            alu_ready_out <= 1'b1;
            alu_result    <= '0;
            alu_flags     <= '0;
        end else if (alu_start) begin
            chk("start_when_ready", {m_busy, alu_ready_out}, 2'b01);
            n_start       <= n_start + 1;
            m_busy        <= 1'b1;
            alu_ready_out <= 1'b0;
            m_op          <= alu_op_code;
            m_lat         <= (alu_lat_fixed > 0) ? alu_lat_fixed : int'($urandom_range(0, 3));
        end else if (m_busy && !alu_valid_out) begin
            if (m_lat == 0) begin
                r = alu_fn(alu_op_a, alu_op_b, alu_op_code);
                alu_valid_out <= 1'b1;
                alu_result    <= r[31:0];
                alu_flags     <= r[36:32];
            end else begin
                m_lat <= m_lat - 1;
            end
        end else if (alu_valid_out && alu_ready_in) begin
            chk("op_code_held", alu_op_code, m_op);
            alu_valid_out <= 1'b0;
            m_busy        <= 1'b0;
            alu_ready_out <= 1'b1;
        end
    end

    // Result monitor: scoreboard compare on handshake, stability while stalled
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_hold) begin
                chk("hold_data", res_data, prev_data);
                chk("hold_tag", res_tag, prev_tag);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {res_tag, res_data}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_tag", res_tag, e.tag);
                    chk("res_data", res_data, e.data);
                    chk("res_flags", res_flags, e.flags);
                    n_rx++;
                end
            end
            if (!m_busy) chk("ready_in_outside_busy", alu_ready_in, 0);
        end
        prev_hold = rst_n && res_valid && !res_ready;
        prev_data = res_data;
        prev_tag  = res_tag;
    end

    // Drive one request until accepted; queue its expected result
    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag);
        logic ok = 1'b0;
        logic [36:0] r;
        exp_t e;
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
        req_mode_fp = 1'b1; req_round = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
        else begin
            if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) r = alu_fn(a, b, op);
            else r = {5'b10000, 32'h0};
            e.tag = tag; e.data = r[31:0]; e.flags = r[36:32];
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin done = 1'b1; break; end
        end
        @(posedge clk); #1;
        chk("drain_done", done, 1);
    endtask

    initial begin
        int s, s_rx;
        logic hit;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        req_tag = '0; req_mode_fp = 1'b0; req_round = 1'b0;
        res_ready = 1'b1; flags_clr = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready_low", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready_high", req_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sticky", flags_sticky, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_op_a", alu_op_a, 0);
        @(posedge clk); #1;

        // 1: single add
        s = n_start;
        push(32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
        wait_idle();
        chk("t1_one_start", n_start - s, 1);
        chk("t1_sticky", flags_sticky, 0);
        chk("t1_mode_held", {alu_mode_fp, alu_round_mode}, 2'b10);

        // 2: back-to-back add, mul, div
        s_rx = n_rx;
        push(32'h3F800000, 32'h40000000, OP_ADD, 4'd0);
        push(32'h40000000, 32'h40400000, OP_MUL, 4'd1);
        push(32'h40C00000, 32'h40000000, OP_DIV, 4'd2);
        wait_idle();
        chk("t2_count", n_rx - s_rx, 3);

        // 3: backpressure with result slot blocked
        res_ready = 1'b0;
        s_rx = n_rx;
        for (int i = 0; i < 5; i++)
            push($urandom, $urandom, 3'(i % 4), 4'(8 + i));
        @(negedge clk);
        chk("t3_full_stall", req_ready, 0);
        @(posedge clk); #1;
        push($urandom, $urandom, OP_SUB, 4'd13);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t3_slot_full", res_valid, 1);
        chk("t3_ready_in_blocked", alu_ready_in, 0);
        chk("t3_nothing_drained", n_rx - s_rx, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_idle();
        chk("t3_all_drained", n_rx - s_rx, 6);

        // 4: divide by zero and sticky clear behaviour
        push(32'h3F800000, 32'h00000000, OP_DIV, 4'd4);
        wait_idle();
        chk("t4_sticky_dz", flags_sticky, 5'b01000);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("t4_sticky_cleared", flags_sticky, 0);
        push(32'h3F800000, 32'h00000000, OP_DIV, 4'd5);
        wait_idle();
        chk("t4_sticky_dz_again", flags_sticky, 5'b01000);
        push(32'h3F800000, 32'h33800000, OP_ADD, 4'd6);
        hit = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (alu_valid_out && alu_ready_in) begin
                flags_clr = 1'b1;
                @(posedge clk); #1;
                flags_clr = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin @(posedge clk); #1; end
        chk("t4_capture_seen", hit, 1);
        chk("t4_sticky_clr_capture", flags_sticky, 5'b00001);
        wait_idle();

        // 5: illegal op then a normal op
        s = n_start;
        push(32'h12345678, 32'h9ABCDEF0, 3'b111, 4'd5);
        push(32'h3F800000, 32'h40000000, OP_ADD, 4'd6);
        wait_idle();
        chk("t5_one_start", n_start - s, 1);
        chk("t5_sticky_nv", flags_sticky[FLAG_NV], 1);

        // 6: reset while busy with two entries queued
        alu_lat_fixed = 8;
        push(32'h11111111, 32'h22222222, OP_ADD, 4'd1);
        push(32'h33333333, 32'h44444444, OP_MUL, 4'd2);
        push(32'h55555555, 32'h66666666, OP_SUB, 4'd3);
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m_busy) begin hit = 1'b1; break; end
        end
        chk("t6_reached_busy", hit, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = n_start;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_sticky", flags_sticky, 0);
        chk("t6_no_start", n_start - s, 0);
        chk("t6_op_a_cleared", alu_op_a, 0);
        alu_lat_fixed = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
